// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU operation codes, funct3/funct7 constants and opcodes
// used by the instruction encoder.
package riscv_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  F7_SUB     = 7'b0100000;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

    // One buffered output entry: the encoded word plus its illegal-request flag.
    typedef struct packed {
        logic        illegal;
        logic [31:0] word;
    } instr_entry_t;

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry pointer-based synchronous FIFO with full/empty flags.
module instr_fifo2 #(
    parameter int unsigned Width = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop_i && !push_i) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/instr_enc.sv
// Streaming RV32I OP/OP-IMM encoder: turns ALU requests into instruction words, buffered
// in a 2-entry FIFO, with emitted and illegal-request counters.
module instr_enc
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  alu_op_e          req_op,
    input  logic             req_is_imm,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [11:0]      req_imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic             instr_illegal,
    output logic [CNT_W-1:0] emit_cnt,
    output logic [7:0]       illegal_cnt
);

    instr_entry_t     enc_entry;
    instr_entry_t     head_entry;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             legal;
    logic             accept;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] emit_cnt_q, emit_cnt_d;
    logic [7:0]       illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        funct3 = F3_ADD_SUB;
        funct7 = 7'b0;
        legal  = 1'b1;
        unique case (req_op)
            ALU_ADD: funct3 = F3_ADD_SUB;
            ALU_SUB: begin
                funct3 = F3_ADD_SUB;
                funct7 = F7_SUB;
                legal  = !req_is_imm;
            end
            ALU_AND: funct3 = F3_AND;
            ALU_OR:  funct3 = F3_OR;
            ALU_SLT: funct3 = F3_SLT;
            default: legal  = 1'b0;
        endcase
    end

    always_comb begin
        enc_entry.illegal = !legal;
        if (!legal) begin
            enc_entry.word = INSTR_NOP;
        end else if (req_is_imm) begin
            enc_entry.word = {req_imm, req_rs1, funct3, req_rd, OPC_OP_IMM};
        end else begin
            enc_entry.word = {funct7, req_rs2, req_rs1, funct3, req_rd, OPC_OP};
        end
    end

    // Ready depends only on registered occupancy, never on instr_ready.
    assign req_ready   = !fifo_full;
    assign accept      = req_valid && req_ready;
    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;

    instr_fifo2 #(
        .Width ($bits(instr_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .wdata_i (enc_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign instr         = head_entry.word;
    assign instr_illegal = head_entry.illegal;

    always_comb begin
        emit_cnt_d    = emit_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (pop) begin
            emit_cnt_d = emit_cnt_q + CNT_W'(1);
        end
        if (accept && enc_entry.illegal && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            emit_cnt_q    <= '0;
            illegal_cnt_q <= '0;
        end else begin
            emit_cnt_q    <= emit_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign emit_cnt    = emit_cnt_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_instr_enc.sv
// Directed bench for instr_enc: a queue-based model checked every cycle, plus literal
// expectations for the hand-encoded instruction words.
module tb_instr_enc;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    alu_op_e     req_op;
    logic        req_is_imm;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [11:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        instr_illegal;
    logic [15:0] emit_cnt;
    logic [7:0]  illegal_cnt;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [32:0] mq[$];
    int          m_emit = 0;
    int          m_icnt = 0;
    bit          model_on = 1'b0;
    bit          m_pop, m_acc;
    logic [32:0] m_entry;

    always #5 clk = ~clk;

    instr_enc #(
        .CNT_W (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_is_imm    (req_is_imm),
        .req_rd        (req_rd),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_imm       (req_imm),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_illegal (instr_illegal),
        .emit_cnt      (emit_cnt),
        .illegal_cnt   (illegal_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding from the ISA field layout; bit 32 is the illegal flag.
    function automatic logic [32:0] model_enc(input int op, input bit is_imm, input int rd,
                                              input int rs1, input int rs2, input int imm);
        longint w;
        int     f3;
        if (op > 4 || (op == 1 && is_imm)) return {1'b1, 32'h0000_0013};
        case (op)
            2:       f3 = 7;
            3:       f3 = 6;
            4:       f3 = 2;
            default: f3 = 0;
        endcase
        w = longint'(rs1) * 32768 + longint'(f3) * 4096 + longint'(rd) * 128;
        if (is_imm) w = w + longint'(imm) * 1048576 + 19;
        else w = w + (op == 1 ? longint'(32) * 33554432 : 0) + longint'(rs2) * 1048576 + 51;
        return {1'b0, w[31:0]};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_emit   = 0;
                m_icnt   = 0;
                model_on = 1'b1;
            end else begin
                m_pop   = instr_ready && (mq.size() > 0);
                m_acc   = req_valid && (mq.size() < 2);
                m_entry = model_enc(int'(req_op), req_is_imm, int'(req_rd), int'(req_rs1),
                                    int'(req_rs2), int'(req_imm));
                if (m_pop) begin
                    void'(mq.pop_front());
                    m_emit = (m_emit + 1) % 65536;
                end
                if (m_acc) begin
                    mq.push_back(m_entry);
                    if (m_entry[32] && m_icnt < 255) m_icnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("instr_valid", 64'(instr_valid), 64'(mq.size() > 0));
                chk("req_ready", 64'(req_ready), 64'(mq.size() < 2));
                chk("emit_cnt", 64'(emit_cnt), 64'(m_emit));
                chk("illegal_cnt", 64'(illegal_cnt), 64'(m_icnt));
                if (mq.size() > 0) begin
                    chk("instr", 64'(instr), 64'(mq[0][31:0]));
                    chk("instr_illegal", 64'(instr_illegal), 64'(mq[0][32]));
                end
            end
        end
    end

    task automatic offer(input int op, input bit is_imm, input int rd, input int rs1,
                         input int rs2, input int imm);
        req_op     = alu_op_e'(op[2:0]);
        req_is_imm = is_imm;
        req_rd     = rd[4:0];
        req_rs1    = rs1[4:0];
        req_rs2    = rs2[4:0];
        req_imm    = imm[11:0];
        req_valid  = 1'b1;
    endtask

    // Returns at negedge+1 after the accepting edge; req_valid left low.
    task automatic wait_accept(input string name);
        int n;
        bit rdy;
        n = 0;
        do begin
            rdy = req_ready;
            @(negedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        req_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL %s: accept timeout, got no accept expected accept", name);
        end
    endtask

    task automatic single(input string name, input int op, input bit is_imm, input int rd,
                          input int rs1, input int rs2, input int imm,
                          input logic [31:0] exp_word, input logic exp_ill);
        offer(op, is_imm, rd, rs1, rs2, imm);
        wait_accept(name);
        chk({name, "_valid"}, 64'(instr_valid), 64'd1);
        chk({name, "_word"}, 64'(instr), 64'(exp_word));
        chk({name, "_ill"}, 64'(instr_illegal), 64'(exp_ill));
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        instr_ready = 1'b1;
        req_op = ALU_ADD;
        req_is_imm = 1'b0;
        req_rd = '0;
        req_rs1 = '0;
        req_rs2 = '0;
        req_imm = '0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_ill", 64'(instr_illegal), 64'd0);
        chk("rst_emit", 64'(emit_cnt), 64'd0);
        chk("rst_icnt", 64'(illegal_cnt), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);

        single("add_r", 0, 1'b0, 3, 1, 2, 0, 32'h002081B3, 1'b0);
        single("sub_r", 1, 1'b0, 5, 6, 7, 0, 32'h407302B3, 1'b0);
        single("addi", 0, 1'b1, 1, 0, 0, 'hFFF, 32'hFFF00093, 1'b0);
        single("slti", 4, 1'b1, 4, 2, 0, 5, 32'h00512213, 1'b0);
        chk("icnt_before", 64'(illegal_cnt), 64'd0);
        single("subi", 1, 1'b1, 1, 1, 0, 1, 32'h00000013, 1'b1);
        chk("icnt_after", 64'(illegal_cnt), 64'd1);
        single("bad_op", 7, 1'b0, 9, 9, 9, 0, 32'h00000013, 1'b1);
        single("or_r", 3, 1'b0, 2, 3, 4, 0, 32'h0041E133, 1'b0);
        single("andi", 2, 1'b1, 8, 9, 0, 'h0F0, 32'h0F04F413, 1'b0);

        // Backpressure: two accepts then req_ready drops.
        pulse_reset();
        instr_ready = 1'b0;
        offer(1, 1'b0, 5, 6, 7, 0);
        wait_accept("bp_a");
        offer(0, 1'b0, 3, 1, 2, 0);
        wait_accept("bp_b");
        offer(4, 1'b1, 4, 2, 0, 5);
        chk("bp_full_ready", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("bp_hold_ready", 64'(req_ready), 64'd0);
        chk("bp_hold_head", 64'(instr), 64'h407302B3);
        chk("bp_hold_emit", 64'(emit_cnt), 64'd0);
        instr_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_second_head", 64'(instr), 64'h002081B3);
        wait_accept("bp_c");
        chk("bp_third_head", 64'(instr), 64'h00512213);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_emit", 64'(emit_cnt), 64'd3);

        // Reset in the middle of a stream.
        offer(0, 1'b0, 1, 2, 3, 0);
        wait_accept("st_0");
        offer(1, 1'b1, 1, 2, 0, 4);
        wait_accept("st_1");
        offer(3, 1'b1, 7, 8, 0, 'h123);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        chk("mid_rst_valid", 64'(instr_valid), 64'd0);
        chk("mid_rst_instr", 64'(instr), 64'd0);
        chk("mid_rst_ill", 64'(instr_illegal), 64'd0);
        chk("mid_rst_emit", 64'(emit_cnt), 64'd0);
        chk("mid_rst_icnt", 64'(illegal_cnt), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        offer(2, 1'b0, 10, 11, 12, 0);
        wait_accept("st_2");
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_emit", 64'(emit_cnt), 64'd1);

        // Illegal counter saturation.
        for (int i = 0; i < 260; i++) begin
            offer(6, 1'b0, i % 32, 0, 0, 0);
            wait_accept("sat");
        end
        repeat (3) @(negedge clk);
        #1;
        chk("icnt_saturate", 64'(illegal_cnt), 64'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
